lsu_mem_initiator: RTL
======================

// Module: lsu_mem_initiator
// PURPOSE
//  Load/store initiator between the execute stage and the data-memory port. Accepts one
//  byte/half/word load or store, drives word-aligned memory accesses with byte strobes,
//  splits accesses that cross a word boundary into two, and returns one response.
//  For loads, the response is sign- or zero-extended.
//  Only one request is outstanding at a time. The pipeline stalls on req_ready.
// PARAMETERS
//  MEM_LATENCY      1  cycles from a mem_en_read cycle until mem_rdata is valid (1..4)
//  ALLOW_MISALIGNED 1  1 = split word-crossing accesses; 0 = return rsp_err instead
// PORTS
//  clk          in   1   clock; all logic on posedge
//  rst_n        in   1   reset, synchronous, active-low
//  req_valid    in   1   request present
//  req_ready    out  1   request accepted on the edge where req_valid && req_ready
//  req_write    in   1   1 = store, 0 = load
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data, LSB-justified
//  req_size     in   2   00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned in   1   load extension: 0 sign, 1 zero
//  rsp_valid    out  1   one-cycle pulse; completes the request
//  rsp_rdata    out  32  extended load data; 0 for stores and errors
//  rsp_err      out  1   illegal size, or misaligned access with ALLOW_MISALIGNED=0
//  mem_en_read  out  1   word read strobe
//  mem_en_write out  1   word write strobe
//  mem_addr     out  32  word address; bits [1:0] are always 00
//  mem_wdata    out  32  lane-shifted store data
//  mem_wstrb    out  4   byte-lane enables; 0 unless mem_en_write
//  mem_rdata    in   32  read word
// BEHAVIOUR
//  - Reset:
//    - While rst_n=0: state=IDLE; every output is 0, including req_ready.
//    - Any in-flight access is abandoned with no response.
//    - req_ready=1 on the first cycle after reset release.
//  - FSM:
//    - IDLE -> LO on accept; IDLE -> RESP on accept with an error (no memory strobe).
//    - LO: mem_en_* asserted for one cycle on word A = addr & ~3.
//    - LO -> WAIT_LO for loads; stores skip the wait states.
//    - WAIT_LO waits MEM_LATENCY cycles, counted by a latency counter.
//    - Split access: then HI (word A+4, 32-bit wrap: 0xFFFFFFFC+4 -> 0), then WAIT_HI.
//    - Every path ends in RESP, which goes to IDLE.
//  - req_ready = (state==IDLE) && rst_n. Request fields are registered on accept.
//    Inputs are ignored in all other states.
//  - Lanes:
//    - m = 1/3/F for byte/half/word; o = addr[1:0]; S = {4'b0,m} << o (8 bits).
//    - Split access iff S[7:4] != 0.
//    - LO strobe = S[3:0]; HI strobe = S[7:4].
//    - D = {32'b0,wdata} << 8*o. LO data = D[31:0]; HI data = D[63:32].
//  - Loads:
//    - Capture mem_rdata into lo/hi registers on the edge MEM_LATENCY cycles after the read cycle.
//    - Form R = {hi,lo} >> 8*o. Take the low 8/16/32 bits and extend per the registered unsigned flag.
//  - Timing, with accept edge T0 and L = MEM_LATENCY:
//    - Aligned store: write cycle T1, rsp_valid T2.
//    - Aligned load: read cycle T1, rsp_valid T2+L.
//    - Split access adds 1 cycle for a store and 1+L cycles for a load.
//    - Error: rsp_valid T1.
//  - Response:
//    - rsp_valid is high for exactly one cycle, in RESP.
//    - rsp_rdata and rsp_err are valid only then, and 0 otherwise.
//  - Never assert mem_en_read and mem_en_write in the same cycle.
//  - Aligned halves and bytes never split. Half at o=3 and word at o!=0 split.
// STRUCTURE
//  - Shared header lsu_defs.vh: SIZE_BYTE/HALF/WORD encodings, FSM state localparams,
//    and the lane-mask table.
//  - Sub-module lsu_lane_align is combinational:
//    - Store direction: size + offset -> 8-bit strobe and 64-bit shifted data.
//    - Load direction: {hi,lo} + offset + size + unsigned -> extended 32-bit result.
//  - Top level holds the FSM, the latency counter, request registers and read-data registers.
// TESTING
//  1. Store word 0xDEADBEEF @0x100 -> one write to 0x100, wstrb=F; rsp_valid at T2, rsp_err=0.
//  2. Memory word 0x80FF7F01 @0x200:
//     - Load byte signed @0x202 -> rsp_rdata=0xFFFFFFFF.
//     - Load byte unsigned @0x202 -> 0x000000FF.
//     - Load half signed @0x202 -> 0xFFFF80FF.
//  3. Store half 0xABCD @0x103 -> write 0x100 strb=8 data[31:24]=CD, then write 0x104 strb=1
//     data[7:0]=AB. rsp_valid at T3.
//  4. Memory words 0x44332211 @0x0 and 0x88776655 @0x4; load word @0x1 with L=2
//     -> reads 0x0 then 0x4; rsp_rdata=0x55443322 at T2+2L+1.
//  5. ALLOW_MISALIGNED=0, word load @0x6 -> no mem strobes, rsp_err=1, rsp_rdata=0 at T1.
//     req_size=11 -> same response.
//  6. rst_n low during WAIT_LO -> no rsp_valid; all outputs 0; req_ready=1 the cycle after release.
//     Word store @0xFFFFFFFE -> writes 0xFFFFFFFC strb=C, then 0x00000000 strb=3.

Source files
------------

// File: rtl/lsu_mem_initiator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_initiator_pkg
//  Purpose  : Shared types, size encodings, FSM states and lane-mask helpers
//             for the load/store memory initiator.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_mem_initiator_pkg;

    // Access size encoding as presented on req_size
    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } lsu_size_e;

    // Initiator FSM states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LO      = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_HI      = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_RESP    = 3'd5
    } lsu_state_e;

    // Unshifted byte-lane masks per access size
    localparam logic [3:0] c_MASK_BYTE = 4'h1;
    localparam logic [3:0] c_MASK_HALF = 4'h3;
    localparam logic [3:0] c_MASK_WORD = 4'hF;

    function automatic logic [3:0] lane_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            SIZE_BYTE: m = c_MASK_BYTE;
            SIZE_HALF: m = c_MASK_HALF;
            SIZE_WORD: m = c_MASK_WORD;
            default:   m = 4'h0;
        endcase
        return m;
    endfunction

    // Byte-lane span across two consecutive words: [3:0] low word, [7:4] high word
    function automatic logic [7:0] lane_span(input logic [1:0] size, input logic [1:0] off);
        return {4'b0000, lane_mask(size)} << off;
    endfunction

    // True when the access touches the following word as well
    function automatic logic crosses_word(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] s;
        s = lane_span(size, off);
        return |s[7:4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_initiator_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_lane_align
//  Purpose  : Combinational lane steering. Store side produces the 8-bit
//             two-word strobe span and 64-bit shifted write data; load side
//             extracts and extends the addressed bytes from {hi,lo}.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_mem_initiator_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_lo_i,
    input  logic [31:0] rdata_hi_i,
    input  logic        unsigned_i,
    output logic [7:0]  strb_o,
    output logic [63:0] wdata_o,
    output logic        split_o,
    output logic [31:0] rdata_o
);

    logic [31:0] w_shift;
    logic        w_sext;

    // Store steering and load extraction/extension
    always_comb begin
        strb_o  = lane_span(size_i, off_i);
        split_o = |strb_o[7:4];
        wdata_o = {32'h0, wdata_i} << {off_i, 3'b000};
        w_shift = 32'({rdata_hi_i, rdata_lo_i} >> {off_i, 3'b000});
        w_sext  = 1'b0;
        rdata_o = w_shift;
        case (size_i)
            SIZE_BYTE: begin
                w_sext  = ~unsigned_i & w_shift[7];
                rdata_o = {{24{w_sext}}, w_shift[7:0]};
            end
            SIZE_HALF: begin
                w_sext  = ~unsigned_i & w_shift[15];
                rdata_o = {{16{w_sext}}, w_shift[15:0]};
            end
            default: rdata_o = w_shift;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mem_initiator
//  Purpose  : Single-outstanding load/store initiator. Issues word-aligned
//             memory accesses with byte strobes, splits word-crossing
//             accesses into two, and returns one extended response.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_initiator
    import lsu_mem_initiator_pkg::*;
#(
    parameter int MEM_LATENCY      = 1,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_en_read,
    output logic        mem_en_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    // Last latency-counter value before read data is valid
    localparam logic [1:0] c_LAT_LAST = 2'(MEM_LATENCY - 1);

    lsu_state_e  state_q, state_d;
    logic [1:0]  lat_q, lat_d;

    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        err_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;

    logic        w_req_err;
    logic        w_accept;
    logic        w_cap_lo;
    logic        w_cap_hi;
    logic [31:0] w_word_a;
    logic [7:0]  w_strb;
    logic [63:0] w_wdata;
    logic        w_split;
    logic [31:0] w_load_data;

    assign w_word_a  = {addr_q[31:2], 2'b00};
    assign w_req_err = (req_size == SIZE_ILLEGAL) ||
                       (!ALLOW_MISALIGNED && crosses_word(req_size, req_addr[1:0]));

    lsu_lane_align u_lane_align (
        .size_i     (size_q),
        .off_i      (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rdata_lo_i (lo_q),
        .rdata_hi_i (hi_q),
        .unsigned_i (unsigned_q),
        .strb_o     (w_strb),
        .wdata_o    (w_wdata),
        .split_o    (w_split),
        .rdata_o    (w_load_data)
    );

    // State register and latency counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lat_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Request fields, captured only on the accept edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_q    <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
        end else if (w_accept) begin
            write_q    <= req_write;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            err_q      <= w_req_err;
        end
    end

    // Read-data capture for the low and high words
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo_q <= 32'h0;
            hi_q <= 32'h0;
        end else begin
            if (w_cap_lo) begin
                lo_q <= mem_rdata;
            end
            if (w_cap_hi) begin
                hi_q <= mem_rdata;
            end
        end
    end

    // Next-state and output decode; all outputs forced low while in reset
    always_comb begin
        state_d      = state_q;
        lat_d        = lat_q;
        w_accept     = 1'b0;
        w_cap_lo     = 1'b0;
        w_cap_hi     = 1'b0;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_rdata    = 32'h0;
        rsp_err      = 1'b0;
        mem_en_read  = 1'b0;
        mem_en_write = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        mem_wstrb    = 4'h0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    state_d  = w_req_err ? ST_RESP : ST_LO;
                end
            end
            ST_LO: begin
                mem_addr = w_word_a;
                lat_d    = 2'd0;
                if (write_q) begin
                    mem_en_write = 1'b1;
                    mem_wstrb    = w_strb[3:0];
                    mem_wdata    = w_wdata[31:0];
                    state_d      = w_split ? ST_HI : ST_RESP;
                end else begin
                    mem_en_read = 1'b1;
                    state_d     = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (lat_q == c_LAT_LAST) begin
                    w_cap_lo = 1'b1;
                    lat_d    = 2'd0;
                    state_d  = w_split ? ST_HI : ST_RESP;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_HI: begin
                // 32-bit wrap is intentional: the word after 0xFFFFFFFC is 0
                mem_addr = w_word_a + 32'd4;
                lat_d    = 2'd0;
                if (write_q) begin
                    mem_en_write = 1'b1;
                    mem_wstrb    = w_strb[7:4];
                    mem_wdata    = w_wdata[63:32];
                    state_d      = ST_RESP;
                end else begin
                    mem_en_read = 1'b1;
                    state_d     = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (lat_q == c_LAT_LAST) begin
                    w_cap_hi = 1'b1;
                    lat_d    = 2'd0;
                    state_d  = ST_RESP;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                rsp_rdata = (write_q || err_q) ? 32'h0 : w_load_data;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!rst_n) begin
            w_accept     = 1'b0;
            req_ready    = 1'b0;
            rsp_valid    = 1'b0;
            rsp_rdata    = 32'h0;
            rsp_err      = 1'b0;
            mem_en_read  = 1'b0;
            mem_en_write = 1'b0;
            mem_addr     = 32'h0;
            mem_wdata    = 32'h0;
            mem_wstrb    = 4'h0;
        end
    end

endmodule
`default_nettype wire
